// File: rtl/tp_sndcmd_tx_pkg.sv
// Shared types and defaults for the Time Pilot main-board sound-command transmitter.
package tp_snd_pkg;

   localparam int unsigned DATA_W      = 8;
   localparam int unsigned GAP_W       = 8;
   localparam int unsigned DEF_DEPTH   = 4;
   localparam int unsigned DEF_GAP_CEN = 64;
   localparam int unsigned CEN_DIV     = 16;

   typedef enum logic [2:0] {
      IDLE,
      PRESENT,
      LATCH,
      IRQ,
      GAP
   } tx_state_e;

endpackage

// File: rtl/tp_sndcmd_tx_if.sv
// Command-side and sound-board-side signal bundle of the sound-command transmitter.
interface tp_sndcmd_tx_if;
   import tp_snd_pkg::*;

   logic              cmd_wr;
   logic [DATA_W-1:0] cmd_data;
   logic              irq_req;
   logic [DATA_W-1:0] cpubrd_Din;
   logic              cs_sounddata;
   logic              irq_trigger;
   logic              fifo_full;
   logic              fifo_empty;
   logic              overflow;
   logic              busy;

   modport master (
      output cmd_wr, cmd_data, irq_req,
      input  cpubrd_Din, cs_sounddata, irq_trigger, fifo_full, fifo_empty, overflow, busy
   );

   modport slave (
      input  cmd_wr, cmd_data, irq_req,
      output cpubrd_Din, cs_sounddata, irq_trigger, fifo_full, fifo_empty, overflow, busy
   );

endinterface

// File: rtl/tp_sndcmd_fifo.sv
// Command-byte FIFO with registered full/empty and a sticky overflow flag.
module tp_sndcmd_fifo
   import tp_snd_pkg::*;
#(
   parameter int unsigned DEPTH = DEF_DEPTH
) (
   input  logic              clk_49m,
   input  logic              reset,
   input  logic              i_push,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_pop,
   output logic [DATA_W-1:0] o_head_c,
   output logic              o_full,
   output logic              o_empty,
   output logic              o_overflow
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PW-1:0]     r_wptr;
   logic [PW-1:0]     r_rptr;
   logic [CW-1:0]     r_cnt;
   logic              r_full;
   logic              r_empty;
   logic              r_ovf;
   logic [CW-1:0]     w_cnt_nxt;
   logic              w_pop_ok;
   logic              w_push_ok;

   // A simultaneous pop frees the slot, so a write into a full FIFO is still taken.
   assign w_pop_ok  = i_pop && !r_empty;
   assign w_push_ok = i_push && (!r_full || w_pop_ok);
   assign w_cnt_nxt = r_cnt + CW'(w_push_ok) - CW'(w_pop_ok);

   always_ff @(posedge clk_49m) begin
      if (w_push_ok) r_mem[r_wptr] <= i_data;
   end

   always_ff @(posedge clk_49m) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_cnt   <= '0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
         r_ovf   <= 1'b0;
      end else begin
         if (w_push_ok) r_wptr <= r_wptr + PW'(1);
         if (w_pop_ok)  r_rptr <= r_rptr + PW'(1);
         r_cnt   <= w_cnt_nxt;
         r_full  <= (w_cnt_nxt == CW'(DEPTH));
         r_empty <= (w_cnt_nxt == '0);
         if (i_push && !w_push_ok) r_ovf <= 1'b1;
      end
   end

   assign o_head_c   = r_mem[r_rptr];
   assign o_full     = r_full;
   assign o_empty    = r_empty;
   assign o_overflow = r_ovf;

endmodule

// File: rtl/tp_sndcmd_tx.sv
// Presents queued command bytes to the sound board latch, pulses its IRQ and paces the next byte.
module tp_sndcmd_tx
   import tp_snd_pkg::*;
#(
   parameter int unsigned DEPTH    = DEF_DEPTH,
   parameter int unsigned GAP_CEN  = DEF_GAP_CEN,
   parameter bit          AUTO_IRQ = 1'b1
) (
   input  logic          clk_49m,
   input  logic          reset,
   input  logic          cen_3m,
   tp_sndcmd_tx_if.slave bus
);

   tx_state_e         r_state;
   logic [DATA_W-1:0] r_din;
   logic              r_cs;
   logic              r_irq;
   logic              r_busy;
   logic              r_pend;
   logic [GAP_W-1:0]  r_gap;
   logic [DATA_W-1:0] w_head;
   logic              w_full;
   logic              w_empty;
   logic              w_ovf;
   logic              w_take_irq;
   logic              w_pop;

   // A pending manual IRQ is served before any queued byte.
   assign w_take_irq = (r_state == IDLE) && r_pend;
   assign w_pop      = (r_state == IDLE) && !r_pend && !w_empty;

   tp_sndcmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_49m    (clk_49m),
      .reset      (reset),
      .i_push     (bus.cmd_wr),
      .i_data     (bus.cmd_data),
      .i_pop      (w_pop),
      .o_head_c   (w_head),
      .o_full     (w_full),
      .o_empty    (w_empty),
      .o_overflow (w_ovf)
   );

   always_ff @(posedge clk_49m) begin
      if (reset) begin
         r_state <= IDLE;
         r_din   <= '0;
         r_cs    <= 1'b0;
         r_irq   <= 1'b0;
         r_busy  <= 1'b0;
         r_pend  <= 1'b0;
         r_gap   <= '0;
      end else begin
         if (!AUTO_IRQ && bus.irq_req) r_pend <= 1'b1;
         else if (w_take_irq)          r_pend <= 1'b0;

         case (r_state)
            IDLE: begin
               if (w_take_irq) begin
                  r_irq   <= 1'b1;
                  r_busy  <= 1'b1;
                  r_state <= IRQ;
               end else if (w_pop) begin
                  r_din   <= w_head;
                  r_busy  <= 1'b1;
                  r_state <= PRESENT;
               end
            end
            PRESENT: begin
               if (cen_3m) begin
                  r_cs    <= 1'b1;
                  r_state <= LATCH;
               end
            end
            // cs_sounddata spans exactly one receiver sample, then drops.
            LATCH: begin
               if (cen_3m) begin
                  r_cs <= 1'b0;
                  if (AUTO_IRQ) begin
                     r_irq   <= 1'b1;
                     r_state <= IRQ;
                  end else begin
                     r_gap   <= GAP_W'(GAP_CEN);
                     r_state <= GAP;
                  end
               end
            end
            IRQ: begin
               if (cen_3m) begin
                  r_irq   <= 1'b0;
                  r_gap   <= GAP_W'(GAP_CEN);
                  r_state <= GAP;
               end
            end
            GAP: begin
               if (r_gap == '0) begin
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end else if (cen_3m) begin
                  r_gap <= r_gap - GAP_W'(1);
               end
            end
            default: begin
               r_cs    <= 1'b0;
               r_irq   <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.cpubrd_Din   = r_din;
   assign bus.cs_sounddata = r_cs;
   assign bus.irq_trigger  = r_irq;
   assign bus.fifo_full    = w_full;
   assign bus.fifo_empty   = w_empty;
   assign bus.overflow     = w_ovf;
   assign bus.busy         = r_busy;

endmodule
